multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WIDTH, default 32: width of instr_count.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles per memory access, legal range 1..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 opcode  input  6  instruction opcode, sampled in DECODE.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  output  1 each  PC and memory strobes.
REQ-008 MemToReg, RegDst, RegWrite, ALUSrcA, Jal  output  1 each  register-file and ALU strobes.
REQ-009 ALUSrcB, ALUOp, PCSource  output  2 each  datapath mux selects and ALU mode.
REQ-010 state  output  4  current state encoding.
REQ-011 fault  output  1  sticky error flag.
REQ-012 instr_count  output  WIDTH  retired-instruction count.

Function
REQ-013 Opcodes SHALL be: R-type 0, LW 4, SW 5, BEQ 6, J 2, JAL 3.
REQ-014 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, FAULT 10.
REQ-015 Any strobe or select not listed for a state SHALL be 0.
REQ-016 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, with IRWrite=PCWrite=mem_ready; it SHALL go to DECODE on mem_ready, else stay.
REQ-017 DECODE SHALL drive ALUSrcB=11, ALUOp=00 and latch opcode internally.
REQ-018 DECODE next state SHALL be: 0 -> EXEC; 4 or 5 -> MEMADR; 6 -> BRANCH; 2 or 3 -> JUMP; any other value per REQ-032/033.
REQ-019 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if the latched opcode is 4, else MEMWR.
REQ-020 MEMRD SHALL drive MemRead=1, IorD=1 and go to MEMWB on mem_ready.
REQ-021 MEMWB SHALL drive RegWrite=1, MemToReg=1, RegDst=0, then go to FETCH.
REQ-022 MEMWR SHALL drive MemWrite=1, IorD=1 and go to FETCH on mem_ready.
REQ-023 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-024 ALUWB SHALL drive RegDst=1, RegWrite=1, then go to FETCH.
REQ-025 BRANCH SHALL drive ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-026 JUMP SHALL drive PCWrite=1, PCSource=10, plus Jal=1 and RegWrite=1 when the latched opcode is 3, then go to FETCH.
REQ-027 FAULT SHALL hold all strobes at 0 and fault=1, and SHALL remain in FAULT until reset.
REQ-028 Memory timeout: a wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle mem_ready is low.
REQ-029 When the wait counter equals MEM_TIMEOUT with mem_ready low, the next state SHALL be FAULT; mem_ready high in that same cycle SHALL win.
REQ-030 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.
REQ-031 instr_count SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP, wrapping from 2^WIDTH-1 to 0.
REQ-031a Zero-wait latency SHALL be: R-type 4, LW 5, SW 4, BEQ 3, J/JAL 3 cycles from FETCH entry to the next FETCH entry.

Configuration
REQ-032 With CTRL_ILLEGAL_TRAP_EN defined, an undefined opcode in DECODE SHALL go to FAULT and SHALL NOT increment instr_count.
REQ-033 Without CTRL_ILLEGAL_TRAP_EN, an undefined opcode SHALL be a NOP: DECODE goes to FETCH and instr_count increments.

Reset
REQ-034 On a clk edge with reset=0: state=FETCH, fault=0, instr_count=0, wait counter=0, latched opcode=0.
REQ-035 While reset=0, every strobe and select output SHALL be 0, including the FETCH Moore outputs.
REQ-036 Reset asserted mid-operation (any state, including FAULT or a pending access) SHALL abort it; the first cycle after release SHALL be FETCH with MemRead=1.

Verification
REQ-037 R-type, opcode=0, mem_ready=1 constant -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_count 0->1.
REQ-038 LW, opcode=4, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemToReg=1; fault=0.
REQ-039 JAL, opcode=3 -> JUMP drives PCWrite=1, PCSource=10, Jal=1, RegWrite=1; J, opcode=2 -> same with Jal=0, RegWrite=0.
REQ-040 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT entered after 4 wait cycles; fault=1 until reset=0, then FETCH.
REQ-041 opcode=63 -> trap build: FAULT and instr_count unchanged; non-trap build: DECODE->FETCH and instr_count +1.
REQ-042 WIDTH=4, 16 BEQ instructions -> instr_count wraps 15->0; reset=0 during MEMWR -> FETCH on release with all counters 0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory timeout and retire counter
//
// Purpose: sequences FETCH/DECODE/execute states of a multicycle datapath,
//   drives the datapath strobes and mux selects as Moore outputs (IRWrite and
//   PCWrite in FETCH follow mem_ready), traps to a sticky FAULT state when a
//   memory access waits too long, and counts retired instructions.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   opcode[5:0]  instruction opcode, sampled in DECODE
//   mem_ready    memory access completes this cycle (FETCH, MEMRD, MEMWR only)
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite   PC/memory strobes
//   MemToReg, RegDst, RegWrite, ALUSrcA, Jal                  regfile/ALU strobes
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]                   mux selects, ALU mode
//   state[3:0]   current state encoding
//   fault        sticky error flag (set while in FAULT)
//   instr_count  retired-instruction count, wraps
// Configuration macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - undefined opcode in DECODE traps to FAULT without retiring
//   undefined - undefined opcode behaves as a NOP and retires

module multicycle_control #(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemToReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic             Jal,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       state,
   output logic             fault,
   output logic [WIDTH-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_FAULT  = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_LW    = 6'd4;
   localparam logic [5:0] OP_SW    = 6'd5;
   localparam logic [5:0] OP_BEQ   = 6'd6;

   localparam logic [7:0]       TIMEOUT   = 8'(MEM_TIMEOUT);
   localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;
   logic [7:0] wait_cnt;
   logic       waiting;
   logic       timed_out;
   logic       retire;

   // Only the three memory-handshake states watch mem_ready.
   assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timed_out = waiting && !mem_ready && (wait_cnt == TIMEOUT);

   // FAULT never leaves except through reset, so any move into FETCH from
   // another state is an instruction completing (including the NOP path).
   assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

   assign state = state_q;
   assign fault = (state_q == S_FAULT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         op_q        <= '0;
         wait_cnt    <= '0;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
         // Any state change clears the counter, which covers entry into
         // each waiting state; it only advances while a wait is stalled.
         if (state_d != state_q) begin
            wait_cnt <= '0;
         end else if (waiting && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (retire) begin
            instr_count <= instr_count + COUNT_ONE;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      Jal         = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            // A completing access wins over a timeout in the same cycle.
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timed_out) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:      state_d = S_EXEC;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_J, OP_JAL:  state_d = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:       state_d = S_FAULT;
`else
               default:       state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timed_out) begin
               state_d = S_FAULT;
            end
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (timed_out) begin
               state_d = S_FAULT;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            if (op_q == OP_JAL) begin
               Jal      = 1'b1;
               RegWrite = 1'b1;
            end
            state_d = S_FETCH;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            // Unused encodings are treated as corruption.
            state_d = S_FAULT;
         end
      endcase

      // Held in reset: no strobe may fire, not even the FETCH Moore outputs.
      if (!reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemToReg    = 1'b0;
         RegDst      = 1'b0;
         RegWrite    = 1'b0;
         ALUSrcA     = 1'b0;
         Jal         = 1'b0;
         ALUSrcB     = 2'b00;
         ALUOp       = 2'b00;
         PCSource    = 2'b00;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control

module tb_multicycle_control;

   localparam int W   = 4;
   localparam int TMO = 4;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_FAULT  = 4'd10;

   logic         clk = 1'b0;
   logic         reset;
   logic [5:0]   opcode;
   logic         mem_ready;
   logic         PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic         MemToReg, RegDst, RegWrite, ALUSrcA, Jal;
   logic [1:0]   ALUSrcB, ALUOp, PCSource;
   logic [3:0]   state;
   logic         fault;
   logic [W-1:0] instr_count;

   multicycle_control #(.WIDTH(W), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .Jal(Jal), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .state(state), .fault(fault),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  st;
      logic [16:0] ctrl;
      logic        flt;
      logic [3:0]  cnt;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   logic [16:0] act_ctrl;
   int    checks = 0;
   int    errors = 0;
   int    m_count = 0;
   int    cyc = 0;

   // Expected strobes per state, packed as
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,Jal,ALUSrcB,ALUOp,PCSource}
   function automatic logic [16:0] ctrl(input logic [3:0] s, input logic rdy, input logic jal);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jl;
      logic [1:0] asb, aop, pcs;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jl} = '0;
      asb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (s)
         S_FETCH:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE: begin asb = 2'b11; end
         S_MEMADR: begin asa = 1; asb = 2'b10; end
         S_MEMRD:  begin mrd = 1; iord = 1; end
         S_MEMWB:  begin rw = 1; m2r = 1; end
         S_MEMWR:  begin mwr = 1; iord = 1; end
         S_EXEC:   begin asa = 1; aop = 2'b10; end
         S_ALUWB:  begin rdst = 1; rw = 1; end
         S_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         S_JUMP:   begin pcw = 1; pcs = 2'b10; jl = jal; rw = jal; end
         default:  ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jl, asb, aop, pcs};
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Drive one cycle of inputs and queue what the DUT must show during it.
   task automatic cycle(input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [3:0] es, input logic [16:0] ec, input logic ef);
      exp_t e;
      reset = rst; opcode = op; mem_ready = rdy;
      e.st = es; e.ctrl = ec; e.flt = ef; e.cnt = 4'(m_count);
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic reset_seq(input logic [3:0] ps, input logic pf);
      cycle(1'b0, rnd_op(), rnd_bit(), ps, 17'd0, pf);
      m_count = 0;
      cycle(1'b0, rnd_op(), rnd_bit(), S_FETCH, 17'd0, 1'b0);
   endtask

   task automatic fault_and_reset();
      repeat (3) cycle(1'b1, rnd_op(), rnd_bit(), S_FAULT, 17'd0, 1'b1);
      reset_seq(S_FAULT, 1'b1);
   endtask

   // A handshake state stalled for 'waits' cycles; more than TMO stalls faults.
   task automatic wait_phase(input logic [3:0] s, input int waits, output logic faulted);
      int n;
      n = (waits > TMO) ? TMO + 1 : waits;
      for (int i = 0; i < n; i++) cycle(1'b1, rnd_op(), 1'b0, s, ctrl(s, 1'b0, 1'b0), 1'b0);
      faulted = (waits > TMO);
      if (!faulted) cycle(1'b1, rnd_op(), 1'b1, s, ctrl(s, 1'b1, 1'b0), 1'b0);
   endtask

   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      logic f;
      wait_phase(S_FETCH, fw, f);
      if (f) begin fault_and_reset(); return; end
      cycle(1'b1, op, rnd_bit(), S_DECODE, ctrl(S_DECODE, 1'b0, 1'b0), 1'b0);
      case (op)
         6'd0: begin
            cycle(1'b1, rnd_op(), rnd_bit(), S_EXEC, ctrl(S_EXEC, 1'b0, 1'b0), 1'b0);
            cycle(1'b1, rnd_op(), rnd_bit(), S_ALUWB, ctrl(S_ALUWB, 1'b0, 1'b0), 1'b0);
         end
         6'd4, 6'd5: begin
            cycle(1'b1, rnd_op(), rnd_bit(), S_MEMADR, ctrl(S_MEMADR, 1'b0, 1'b0), 1'b0);
            wait_phase((op == 6'd4) ? S_MEMRD : S_MEMWR, mw, f);
            if (f) begin fault_and_reset(); return; end
            if (op == 6'd4) cycle(1'b1, rnd_op(), rnd_bit(), S_MEMWB, ctrl(S_MEMWB, 1'b0, 1'b0), 1'b0);
         end
         6'd6: cycle(1'b1, rnd_op(), rnd_bit(), S_BRANCH, ctrl(S_BRANCH, 1'b0, 1'b0), 1'b0);
         6'd2, 6'd3: cycle(1'b1, rnd_op(), rnd_bit(), S_JUMP, ctrl(S_JUMP, 1'b0, op == 6'd3), 1'b0);
         default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            fault_and_reset();
            return;
`endif
         end
      endcase
      m_count = (m_count + 1) % 16;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                     RegDst, RegWrite, ALUSrcA, Jal, ALUSrcB, ALUOp, PCSource};
         checks++;
         if (state !== mon_e.st || act_ctrl !== mon_e.ctrl || fault !== mon_e.flt ||
             instr_count !== mon_e.cnt) begin
            errors++;
            $display("FAIL cycle%0d state=%0d exp %0d ctrl=%h exp %h fault=%b exp %b count=%0d exp %0d",
                     cyc, state, mon_e.st, act_ctrl, mon_e.ctrl, fault, mon_e.flt,
                     instr_count, mon_e.cnt);
         end
      end
   end

   initial begin
      logic [5:0] op;
      logic f;
      int sel;
      reset = 1'b0; opcode = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, strobes forced low even though FETCH is current.
      cycle(1'b0, 6'd0, 1'b1, S_FETCH, 17'd0, 1'b0);
      cycle(1'b0, 6'd0, 1'b0, S_FETCH, 17'd0, 1'b0);

      run_instr(6'd0, 0, 0);       // R-type, zero wait
      run_instr(6'd4, 0, 3);       // LW with three stalls in MEMRD
      run_instr(6'd3, 1, 0);       // JAL
      run_instr(6'd2, 0, 0);       // J
      run_instr(6'd5, 4, 4);       // SW at the edge of the timeout
      run_instr(6'd6, 0, 0);       // BEQ
      run_instr(6'd0, 5, 0);       // FETCH timeout -> FAULT -> reset
      run_instr(6'd63, 0, 0);      // undefined opcode
      run_instr(6'd4, 0, 5);       // MEMRD timeout

      // Reset in the middle of a stalled store.
      wait_phase(S_FETCH, 0, f);
      cycle(1'b1, 6'd5, 1'b1, S_DECODE, ctrl(S_DECODE, 1'b0, 1'b0), 1'b0);
      cycle(1'b1, rnd_op(), 1'b1, S_MEMADR, ctrl(S_MEMADR, 1'b0, 1'b0), 1'b0);
      repeat (2) cycle(1'b1, rnd_op(), 1'b0, S_MEMWR, ctrl(S_MEMWR, 1'b0, 1'b0), 1'b0);
      reset_seq(S_MEMWR, 1'b0);
      run_instr(6'd0, 4, 0);       // wait counter must restart from zero

      // Counter wrap: 16 branches bring a 4-bit count back around.
      repeat (16) run_instr(6'd6, $urandom_range(0, 2), 0);

      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 7);
         case (sel)
            0: op = 6'd0;
            1: op = 6'd4;
            2: op = 6'd5;
            3: op = 6'd6;
            4: op = 6'd2;
            5: op = 6'd3;
            6: op = 6'($urandom_range(7, 63));
            default: op = 6'd1;
         endcase
         run_instr(op, ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, 4),
                   ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, 4));
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time expired");
      $fatal(1);
   end

endmodule
